// File: rtl/din_debounce_if.sv
// Signal bundle between the debouncer and its consumer.
// The slave side is the debouncer; the master side drives the raw input and the controls.
interface din_debounce_if #(
    parameter int GLITCH_W = 8
);
    logic                din;
    logic                en;
    logic                glitch_clr;
    logic                dout;
    logic                rise_pulse;
    logic                fall_pulse;
    logic                busy;
    logic [GLITCH_W-1:0] glitch_cnt;

    modport master (
        output din, en, glitch_clr,
        input  dout, rise_pulse, fall_pulse, busy, glitch_cnt
    );

    modport slave (
        input  din, en, glitch_clr,
        output dout, rise_pulse, fall_pulse, busy, glitch_cnt
    );
endinterface

// File: rtl/din_debounce.sv
// Synchronises and debounces an asynchronous input, with edge pulses,
// a qualify-in-progress flag and a saturating count of aborted transitions.
module din_debounce #(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 16,
    parameter int   GLITCH_W      = 8,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic           clk,
    input  logic           reset_n,
    din_debounce_if.slave  bus
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    // Counter value on the edge that completes the qualification.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {STABLE, QUALIFY} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_n;
    logic [CNT_W-1:0]       cnt_q, cnt_n;
    logic                   dout_q, dout_n;
    logic                   rise_q, rise_n;
    logic                   fall_q, fall_n;
    logic                   busy_q;
    logic                   glitch;
    logic [GLITCH_W-1:0]    glitch_q, glitch_n;

    assign s = sync_q[SYNC_STAGES-1];

    // The synchroniser runs regardless of en so it never holds stale data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= {SYNC_STAGES{RESET_VAL}};
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], bus.din};
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        dout_n  = dout_q;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        glitch  = 1'b0;
        if (bus.en) begin
            case (state_q)
                STABLE: begin
                    if (s != dout_q) begin
                        if (STABLE_CYCLES == 1) begin
                            dout_n = s;
                            rise_n = s;
                            fall_n = ~s;
                        end else begin
                            state_n = QUALIFY;
                            cnt_n   = CNT_W'(1);
                        end
                    end
                end
                QUALIFY: begin
                    if (s != dout_q) begin
                        if (cnt_q == LAST) begin
                            dout_n  = s;
                            cnt_n   = '0;
                            state_n = STABLE;
                            rise_n  = s;
                            fall_n  = ~s;
                        end else begin
                            cnt_n = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_n   = '0;
                        state_n = STABLE;
                        glitch  = 1'b1;
                    end
                end
                default: begin
                    state_n = STABLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Clear wins over a same-cycle glitch so software sees a clean zero.
    always_comb begin
        glitch_n = glitch_q;
        if (bus.glitch_clr)                 glitch_n = '0;
        else if (glitch && (glitch_q != '1)) glitch_n = glitch_q + GLITCH_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= STABLE;
            cnt_q    <= '0;
            dout_q   <= RESET_VAL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            busy_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            dout_q   <= dout_n;
            rise_q   <= rise_n;
            fall_q   <= fall_n;
            busy_q   <= (state_n == QUALIFY);
            glitch_q <= glitch_n;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.rise_pulse = rise_q;
    assign bus.fall_pulse = fall_q;
    assign bus.busy       = busy_q;
    assign bus.glitch_cnt = glitch_q;
endmodule

// File: tb/tb_din_debounce.sv
// Directed bench: three debouncer instances (4-cycle/8-bit, 4-cycle/2-bit, 1-cycle).
module tb_din_debounce;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    din_debounce_if #(.GLITCH_W(8)) bus_a ();
    din_debounce_if #(.GLITCH_W(2)) bus_b ();
    din_debounce_if #(.GLITCH_W(8)) bus_c ();

    din_debounce #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .GLITCH_W(8), .RESET_VAL(1'b0))
        dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
    din_debounce #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .GLITCH_W(2), .RESET_VAL(1'b0))
        dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));
    din_debounce #(.SYNC_STAGES(2), .STABLE_CYCLES(1), .GLITCH_W(8), .RESET_VAL(1'b0))
        dut_c (.clk(clk), .reset_n(reset_n), .bus(bus_c));

    // Advance one rising edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus_a.din = 0; bus_a.en = 1; bus_a.glitch_clr = 0;
        bus_b.din = 0; bus_b.en = 1; bus_b.glitch_clr = 0;
        bus_c.din = 0; bus_c.en = 1; bus_c.glitch_clr = 0;
        reset_n = 0;
        repeat (3) step();
        reset_n = 1;
        repeat (3) step();
        n_vec++;
        if ({bus_a.dout, bus_a.rise_pulse, bus_a.fall_pulse, bus_a.busy, bus_a.glitch_cnt} !== 12'h000) begin
            n_miss++;
            $display("FAIL reset_a: got dout=%b r=%b f=%b busy=%b gc=%0d, want all 0",
                     bus_a.dout, bus_a.rise_pulse, bus_a.fall_pulse, bus_a.busy, bus_a.glitch_cnt);
        end
        n_vec++;
        if ({bus_c.dout, bus_c.busy, bus_c.glitch_cnt} !== 10'h000) begin
            n_miss++;
            $display("FAIL reset_c: got dout=%b busy=%b gc=%0d, want 0", bus_c.dout, bus_c.busy, bus_c.glitch_cnt);
        end
    endtask

    task automatic test_rise();
        bus_a.din = 1;
        for (int e = 1; e <= 8; e++) begin
            step();
            n_vec++;
            if ({bus_a.dout, bus_a.rise_pulse, bus_a.fall_pulse, bus_a.busy} !==
                {logic'(e >= 6), logic'(e == 6), 1'b0, logic'(e >= 3 && e <= 5)}) begin
                n_miss++;
                $display("FAIL rise e%0d: got dout/r/f/busy=%b%b%b%b want %b%b0%b", e,
                         bus_a.dout, bus_a.rise_pulse, bus_a.fall_pulse, bus_a.busy,
                         e >= 6, e == 6, e >= 3 && e <= 5);
            end
        end
    endtask

    task automatic test_en_hold();
        bus_a.din = 0;
        repeat (3) step();
        n_vec++;
        if (bus_a.busy !== 1'b1) begin
            n_miss++;
            $display("FAIL en_busy_rise: got busy=%b want 1", bus_a.busy);
        end
        bus_a.en = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_vec++;
            if ({bus_a.dout, bus_a.busy, bus_a.rise_pulse, bus_a.fall_pulse} !== 4'b1100) begin
                n_miss++;
                $display("FAIL en_hold c%0d: got dout/busy/r/f=%b%b%b%b want 1100", i,
                         bus_a.dout, bus_a.busy, bus_a.rise_pulse, bus_a.fall_pulse);
            end
        end
        // Counter was at 1: two more counting edges, third edge completes.
        bus_a.en = 1;
        for (int e = 1; e <= 5; e++) begin
            step();
            n_vec++;
            if ({bus_a.dout, bus_a.fall_pulse, bus_a.rise_pulse, bus_a.busy} !==
                {logic'(e < 3), logic'(e == 3), 1'b0, logic'(e < 3)}) begin
                n_miss++;
                $display("FAIL en_resume e%0d: got dout/f/r/busy=%b%b%b%b want %b%b0%b", e,
                         bus_a.dout, bus_a.fall_pulse, bus_a.rise_pulse, bus_a.busy,
                         e < 3, e == 3, e < 3);
            end
        end
    endtask

    task automatic test_glitch();
        bus_a.din = 1;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 3) bus_a.din = 0;
            n_vec++;
            if ({bus_a.dout, bus_a.rise_pulse, bus_a.fall_pulse, bus_a.busy} !==
                {3'b000, logic'(e >= 3 && e <= 5)} || bus_a.glitch_cnt !== 8'(e >= 6 ? 1 : 0)) begin
                n_miss++;
                $display("FAIL glitch e%0d: got dout/r/f/busy=%b%b%b%b gc=%0d want 000%b gc=%0d", e,
                         bus_a.dout, bus_a.rise_pulse, bus_a.fall_pulse, bus_a.busy, bus_a.glitch_cnt,
                         e >= 3 && e <= 5, e >= 6 ? 1 : 0);
            end
        end
    endtask

    task automatic test_saturate();
        int exp_cnt [6] = '{1, 2, 3, 3, 3, 0};
        for (int g = 0; g < 6; g++) begin
            bus_b.din = 1;
            for (int e = 1; e <= 7; e++) begin
                step();
                if (e == 2) bus_b.din = 0;
                if (g == 5) bus_b.glitch_clr = (e == 4);
                if (e == 5) begin
                    n_vec++;
                    if (bus_b.glitch_cnt !== 2'(exp_cnt[g]) || bus_b.dout !== 1'b0) begin
                        n_miss++;
                        $display("FAIL sat g%0d: got gc=%0d dout=%b want gc=%0d dout=0",
                                 g, bus_b.glitch_cnt, bus_b.dout, exp_cnt[g]);
                    end
                end
            end
        end
        bus_b.glitch_clr = 0;
    endtask

    task automatic test_reset_mid();
        bus_a.din = 1;
        repeat (4) step();
        n_vec++;
        if (bus_a.busy !== 1'b1) begin
            n_miss++;
            $display("FAIL mid_busy: got busy=%b want 1", bus_a.busy);
        end
        #2 reset_n = 0;
        #1;
        n_vec++;
        if ({bus_a.dout, bus_a.rise_pulse, bus_a.fall_pulse, bus_a.busy, bus_a.glitch_cnt} !== 12'h000) begin
            n_miss++;
            $display("FAIL mid_reset: got dout=%b r=%b f=%b busy=%b gc=%0d want all 0",
                     bus_a.dout, bus_a.rise_pulse, bus_a.fall_pulse, bus_a.busy, bus_a.glitch_cnt);
        end
        @(negedge clk);
        reset_n = 1;
        for (int e = 1; e <= 7; e++) begin
            step();
            n_vec++;
            if ({bus_a.dout, bus_a.rise_pulse, bus_a.busy, bus_a.glitch_cnt} !==
                {logic'(e >= 6), logic'(e == 6), logic'(e >= 3 && e <= 5), 8'd0}) begin
                n_miss++;
                $display("FAIL requal e%0d: got dout/r/busy=%b%b%b gc=%0d want %b%b%b gc=0", e,
                         bus_a.dout, bus_a.rise_pulse, bus_a.busy, bus_a.glitch_cnt,
                         e >= 6, e == 6, e >= 3 && e <= 5);
            end
        end
    endtask

    task automatic test_single_cycle();
        bus_c.din = 1;
        for (int e = 1; e <= 4; e++) begin
            step();
            n_vec++;
            if ({bus_c.dout, bus_c.rise_pulse, bus_c.fall_pulse, bus_c.busy} !==
                {logic'(e >= 3), logic'(e == 3), 2'b00}) begin
                n_miss++;
                $display("FAIL sc1_rise e%0d: got dout/r/f/busy=%b%b%b%b want %b%b00", e,
                         bus_c.dout, bus_c.rise_pulse, bus_c.fall_pulse, bus_c.busy, e >= 3, e == 3);
            end
        end
        bus_c.din = 0;
        for (int e = 1; e <= 4; e++) begin
            step();
            n_vec++;
            if ({bus_c.dout, bus_c.rise_pulse, bus_c.fall_pulse} !== {logic'(e < 3), 1'b0, logic'(e == 3)}) begin
                n_miss++;
                $display("FAIL sc1_fall e%0d: got dout/r/f=%b%b%b want %b0%b", e,
                         bus_c.dout, bus_c.rise_pulse, bus_c.fall_pulse, e < 3, e == 3);
            end
        end
        bus_c.din = 1;
        for (int e = 1; e <= 5; e++) begin
            step();
            if (e == 1) bus_c.din = 0;
            n_vec++;
            if ({bus_c.dout, bus_c.rise_pulse, bus_c.fall_pulse} !==
                {logic'(e == 3), logic'(e == 3), logic'(e == 4)}) begin
                n_miss++;
                $display("FAIL sc1_pulse e%0d: got dout/r/f=%b%b%b want %b%b%b", e,
                         bus_c.dout, bus_c.rise_pulse, bus_c.fall_pulse, e == 3, e == 3, e == 4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_en_hold();
        test_glitch();
        test_saturate();
        test_reset_mid();
        test_single_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/din_debounce.md
Name: din_debounce

Overview:
- Input-conditioning stage directly upstream of the async-reset registered stage. Cleans the signal that stage samples as `a`.
- Synchronises an asynchronous, bouncy input into the `clk` domain and filters it. The output changes only after the synchronised input has held a new level for STABLE_CYCLES consecutive enabled cycles.
- Also provides one-cycle edge pulses, a busy flag and a saturating glitch counter for debug.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops; legal range is 2 or more.
- STABLE_CYCLES, 16, consecutive differing samples required before `dout` flips; legal range is 1 or more.
- GLITCH_W, 8, width of the glitch counter.
- RESET_VAL, 1'b0, reset level of `dout` and of every synchroniser flop.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset. Assertion takes effect immediately; release is synchronous to `clk` externally.
- din  input  1  raw asynchronous input.
- en  input  1  filter enable.
- glitch_clr  input  1  synchronous clear of `glitch_cnt`.
- dout  output  1  debounced level; feeds the downstream `a`.
- rise_pulse  output  1  one-cycle pulse when `dout` goes 0->1.
- fall_pulse  output  1  one-cycle pulse when `dout` goes 1->0.
- busy  output  1  high while a candidate transition is being qualified.
- glitch_cnt  output  GLITCH_W  count of aborted candidate transitions, saturating.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - sync chain = RESET_VAL; dout = RESET_VAL.
  - state = STABLE; stable counter = 0.
  - rise_pulse = fall_pulse = 0; busy = 0; glitch_cnt = 0.
  - Because the sync chain resets to RESET_VAL, no pulse is generated on reset release.
- Synchroniser:
  - SYNC_STAGES-flop shift chain, always running, independent of `en`.
  - `s` is the last flop's output.
- Counter:
  - Stable counter width = $clog2(STABLE_CYCLES+1).
- FSM states:
  - STABLE: `s` == dout, counter = 0.
  - QUALIFY: `s` != dout, counting.
- Per rising edge with en=1:
  - STABLE and s!=dout: if STABLE_CYCLES==1, flip dout immediately and stay in STABLE. Otherwise go to QUALIFY with counter=1.
  - QUALIFY and s!=dout: counter+1. When counter+1 == STABLE_CYCLES, then: dout <= s; counter <= 0; state <= STABLE; the matching pulse is asserted for the next cycle only.
  - QUALIFY and s==dout (glitch): counter <= 0; state <= STABLE; glitch_cnt increments and saturates at all-ones.
  - STABLE and s==dout: hold.
- en=0:
  - state, counter and dout hold; pulses are 0; glitches are not counted.
  - On en=1 the FSM resumes from the held state and counter.
- Latency:
  - Take the first edge that samples a new din level as edge 1.
  - dout shows the new value after edge SYNC_STAGES+STABLE_CYCLES, provided din stays constant and en=1 throughout.
  - rise_pulse / fall_pulse are high in exactly that same cycle, coincident with the new dout.
- Output decodes:
  - busy = (state==QUALIFY), a registered decode.
  - rise_pulse and fall_pulse are never both high.
- glitch_clr:
  - Synchronous clear to 0 on the next edge.
  - Takes priority over a simultaneous glitch increment, so the result is 0.
- Reset mid-operation:
  - Reset asserted during QUALIFY aborts the qualification immediately.
  - dout returns to RESET_VAL with no pulse; glitch_cnt is not incremented.
- All outputs are registered; there is no combinational path from din or en to any output.

Test Plan:
- Params SYNC_STAGES=2, STABLE_CYCLES=4, RESET_VAL=0. Reset, then drive din=1 steadily -> dout=1 after edge 6; rise_pulse high in that cycle only; busy high from after edge 3 to after edge 5.
- din=1 for 3 cycles then back to 0 -> dout stays 0; no pulses; glitch_cnt=1; busy falls.
- GLITCH_W=2, five separate 2-cycle glitches -> glitch_cnt = 1, 2, 3, 3, 3. Then glitch_clr coincident with a sixth glitch -> glitch_cnt=0.
- With dout=1, drive din=0 and hold en=0 for 10 cycles after busy rises -> dout holds 1 and counter is frozen. With en=1 the remaining qualification completes and fall_pulse fires once.
- Assert reset_n=0 mid-QUALIFY (counter=2) -> outputs go to reset values immediately, no pulse, glitch_cnt=0. With din still 1 after release -> a full 6-edge qualification is required again.
- STABLE_CYCLES=1 -> dout follows din after edge 3. A 1-cycle din pulse still propagates, giving a rise_pulse followed by a fall_pulse.
